uart_tx_fifo: RTL and testbench

- Serial transmitter that drains a show-ahead FIFO read port and shifts each word out as an asynchronous serial frame.
- Frame format: start bit, DATA_W data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Sits directly downstream of the tx FIFO in the UART/MIDI peripherals. Connect to the FIFO read side with PROT_RD=1 and REG_OUT=0.

---
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Serial transmitter fed from a show-ahead FIFO read port.
// Each popped word is sent as start, DATA_W data bits LSB first, optional parity, and STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_rdy_i,
    output logic              fifo_rd_o,
    output logic              tx_o,
    output logic              busy_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   word_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic                div_zero;
    logic                last_stop;
    logic                parity_bit;

    assign div_zero   = (div_cnt == '0);
    assign last_stop  = (state == STOP) && div_zero && (bit_cnt == CNT_W'(STOP_BITS - 1));
    assign parity_bit = (^word_q) ^ (PARITY == 2);

    // Show-ahead handshake: fifo_data_i is valid whenever fifo_rdy_i=1, and the
    // word is consumed on the edge where fifo_rd_o=1. A pop is offered only in
    // IDLE or in the final cycle of the last stop bit, so frames run back to back.
    assign fifo_rd_o = fifo_rdy_i && ((state == IDLE) || last_stop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            shift_q <= '0;
            word_q  <= '0;
            div_q   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (fifo_rd_o) begin
            state   <= START;
            tx_o    <= 1'b0;
            busy_o  <= 1'b1;
            shift_q <= fifo_data_i;
            word_q  <= fifo_data_i;
            div_q   <= baud_div_i;
            div_cnt <= baud_div_i;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
                START: begin
                    if (div_zero) begin
                        state   <= DATA;
                        tx_o    <= shift_q[0];
                        div_cnt <= div_q;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (div_zero) begin
                        div_cnt <= div_q;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PARITY_BIT;
                                tx_o  <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_o    <= shift_q[1];
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                PARITY_BIT: begin
                    if (div_zero) begin
                        state   <= STOP;
                        tx_o    <= 1'b1;
                        div_cnt <= div_q;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (div_zero) begin
                        // The pop case of the last stop bit is handled above.
                        if (last_stop) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            tx_o    <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            div_cnt <= div_q;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four lanes (no parity, even, odd, two stop bits) each
// with its own FIFO model and a per-cycle expected line stream built from the frame rules.
module tb_uart_tx_fifo;
    logic        clk;
    logic        rst;
    logic [15:0] baud;
    int          checks;
    int          errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar k = 0; k < 4; k++) begin : lane
        localparam int PAR   = (k == 1) ? 1 : (k == 2) ? 2 : 0;
        localparam int STOPS = (k == 3) ? 2 : 1;

        logic       rdy;
        logic       rd;
        logic       tx;
        logic       busy;
        logic [7:0] data;
        logic       en;
        logic [7:0] src_q[$];
        logic [0:0] exp_q[$];
        int         busy_cnt;
        int         pops;

        uart_tx_fifo #(
            .DATA_W(8), .DIV_W(16), .PARITY(PAR), .STOP_BITS(STOPS)
        ) dut (
            .clk_i(clk), .rst_i(rst), .baud_div_i(baud),
            .fifo_data_i(data), .fifo_rdy_i(rdy), .fifo_rd_o(rd),
            .tx_o(tx), .busy_o(busy)
        );

        initial begin
            en = 1'b0; rdy = 1'b0; data = 8'h00; busy_cnt = 0; pops = 0;
        end

        task automatic refresh();
            rdy  = en && (src_q.size() > 0);
            data = rdy ? src_q[0] : 8'($urandom);
        endtask

        task automatic push(input logic [7:0] w);
            src_q.push_back(w);
            refresh();
        endtask

        task automatic set_en(input logic v);
            en = v;
            refresh();
        endtask

        // Expected line level for every clock of the frame, one entry per cycle.
        task automatic add_frame(input logic [7:0] w, input int div);
            logic bits[$];
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(w[i]);
            if (PAR != 0) bits.push_back((^w) ^ (PAR == 2));
            for (int s = 0; s < STOPS; s++) bits.push_back(1'b1);
            foreach (bits[b])
                for (int r = 0; r <= div; r++) exp_q.push_back(bits[b]);
        endtask

        always @(posedge clk) begin
            if (rd && !rst && src_q.size() > 0) void'(src_q.pop_front());
            #1 refresh();
        end

        always @(negedge clk) begin : model
            logic exp_tx;
            logic exp_busy;
            logic exp_rd;
            if (rst) begin
                exp_q.delete();
            end else begin
                exp_tx   = (exp_q.size() > 0) ? exp_q[0][0] : 1'b1;
                exp_busy = (exp_q.size() > 0);
                exp_rd   = rdy && (exp_q.size() <= 1);
                check($sformatf("lane%0d tx", k), 32'(tx), 32'(exp_tx));
                check($sformatf("lane%0d busy", k), 32'(busy), 32'(exp_busy));
                check($sformatf("lane%0d rd", k), 32'(rd), 32'(exp_rd));
                if (busy) busy_cnt++;
                if (rd) pops++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_rd) add_frame(data, int'(baud));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        lane[0].busy_cnt = 0; lane[0].pops = 0;
        lane[1].busy_cnt = 0; lane[1].pops = 0;
        lane[2].busy_cnt = 0; lane[2].pops = 0;
        lane[3].busy_cnt = 0; lane[3].pops = 0;
    endtask

    function automatic logic all_idle();
        return lane[0].src_q.size() == 0 && !lane[0].busy &&
               lane[1].src_q.size() == 0 && !lane[1].busy &&
               lane[2].src_q.size() == 0 && !lane[2].busy &&
               lane[3].src_q.size() == 0 && !lane[3].busy;
    endfunction

    task automatic push_lane(input int l, input logic [7:0] w);
        case (l)
            0: lane[0].push(w);
            1: lane[1].push(w);
            2: lane[2].push(w);
            default: lane[3].push(w);
        endcase
    endtask

    task automatic en_lane(input int l, input logic v);
        case (l)
            0: lane[0].set_en(v);
            1: lane[1].set_en(v);
            2: lane[2].set_en(v);
            default: lane[3].set_en(v);
        endcase
    endtask

    initial begin : main
        int waited;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        baud   = 16'd3;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset tx", 32'(lane[0].tx), 32'd1);
        check("reset busy", 32'(lane[0].busy), 32'd0);
        check("reset rd", 32'(lane[0].rd), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: single 0xA5 frame, 4 clocks per bit
        clr_counts();
        lane[0].set_en(1'b1);
        lane[0].push(8'hA5);
        cycles(50);
        check("t1 busy clocks", 32'(lane[0].busy_cnt), 32'd40);
        check("t1 pops", 32'(lane[0].pops), 32'd1);

        // 2: even and odd parity on 0x07
        clr_counts();
        lane[1].set_en(1'b1); lane[2].set_en(1'b1);
        lane[1].push(8'h07);  lane[2].push(8'h07);
        cycles(50);
        check("t2 even busy", 32'(lane[1].busy_cnt), 32'd44);
        check("t2 odd busy", 32'(lane[2].busy_cnt), 32'd44);

        // 3: back-to-back frames at one clock per bit
        clr_counts();
        baud = 16'd0;
        lane[0].set_en(1'b0);
        lane[0].push(8'h00); lane[0].push(8'hFF); lane[0].push(8'h55);
        lane[0].set_en(1'b1);
        cycles(40);
        check("t3 busy clocks", 32'(lane[0].busy_cnt), 32'd30);
        check("t3 pops", 32'(lane[0].pops), 32'd3);

        // 4: empty FIFO keeps the line idle
        clr_counts();
        lane[0].set_en(1'b0);
        lane[0].push(8'h99);
        cycles(100);
        check("t4 pops", 32'(lane[0].pops), 32'd0);
        check("t4 busy", 32'(lane[0].busy_cnt), 32'd0);
        lane[0].src_q.delete();
        lane[0].refresh();

        // 5: async reset mid-DATA
        baud = 16'd3;
        lane[0].push(8'h3C);
        lane[0].set_en(1'b1);
        cycles(14);
        lane[0].push(8'h81);
        @(negedge clk);
        check("t5 busy before rst", 32'(lane[0].busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5 async tx", 32'(lane[0].tx), 32'd1);
        check("t5 async busy", 32'(lane[0].busy), 32'd0);
        cycles(3);
        clr_counts();
        rst = 1'b0;
        cycles(50);
        check("t5 pops after rst", 32'(lane[0].pops), 32'd1);
        check("t5 busy after rst", 32'(lane[0].busy_cnt), 32'd40);

        // 6: divisor change mid-frame applies to the next frame only
        clr_counts();
        lane[0].set_en(1'b0);
        lane[0].push(8'h12); lane[0].push(8'h34);
        lane[0].set_en(1'b1);
        waited = 0;
        while (!lane[0].rd && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("t6 pop seen", 32'(lane[0].rd), 32'd1);
        cycles(10);
        baud = 16'd7;
        cycles(140);
        check("t6 busy clocks", 32'(lane[0].busy_cnt), 32'd120);
        check("t6 pops", 32'(lane[0].pops), 32'd2);

        // Random traffic on all lanes
        for (int c = 0; c < 2500; c++) begin
            int l;
            l = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) push_lane(l, 8'($urandom));
            if ($urandom_range(0, 15) == 0) en_lane(int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 63) == 0) baud = 16'($urandom_range(0, 3));
            cycles(1);
        end

        // Drain everything
        en_lane(0, 1'b1); en_lane(1, 1'b1); en_lane(2, 1'b1); en_lane(3, 1'b1);
        waited = 0;
        while (!all_idle() && waited < 3000) begin
            cycles(1);
            waited++;
        end
        check("drain idle", 32'(all_idle()), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
